logic_seq_32_bit: RTL
=====================

Name: logic_seq_32_bit

Overview:
- Multicycle, slice-serial bitwise logic unit. It acts as the responder to the ALU control's logic-operation requests.
- Accepts AND/OR/NOR/NOT requests on a valid/ready handshake and computes SLICE_WIDTH bits per cycle.
- Returns the 32-bit result and a zero flag on a second valid/ready handshake.
- Sits beside the combinational ALU datapath as the area-reduced logic path for the multicycle processor model.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SLICE_WIDTH, 4, bits processed per BUSY cycle; must divide DATA_WIDTH evenly.
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH (8), derived; not overridable.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  unit can accept a request.
- OP  input  2  operation: 00 AND, 01 OR, 10 NOR, 11 NOT A (B ignored).
- A  input  DATA_WIDTH  operand A, sampled on request handshake.
- B  input  DATA_WIDTH  operand B, sampled on request handshake.
- RSP_VALID  output  1  result present.
- RSP_READY  input  1  consumer accepts result.
- Y  output  DATA_WIDTH  result.
- ZERO  output  1  high when Y == 0; meaningful only while RSP_VALID = 1.

Behaviour:
- Clocking and reset: one clock (CLK). RST is synchronous and active-high. RST sampled high at a rising edge forces the reset state regardless of any other input.
- Reset state: state = IDLE, slice counter = 0, Y = 0, RSP_VALID = 0, ZERO = 0.
- REQ_READY is 0 while RST = 1. Otherwise REQ_READY = (state == IDLE).
- States: IDLE, BUSY, DONE, with 2-bit encoding from the package.
- IDLE:
  - On an edge where REQ_VALID & REQ_READY, register A, B and OP, clear the counter to 0, clear Y to 0, and go to BUSY.
  - If REQ_VALID is low, stay in IDLE.
- BUSY:
  - Each edge writes Y[cnt*SLICE_WIDTH +: SLICE_WIDTH] = op(A_r, B_r) slice, then increments cnt.
  - On the edge that processes cnt == NUM_SLICES-1, go to DONE and set RSP_VALID = 1.
  - REQ_VALID is ignored in BUSY (REQ_READY = 0).
- DONE:
  - RSP_VALID = 1. Y and ZERO are stable and held indefinitely while RSP_READY = 0.
  - On an edge with RSP_READY = 1, clear RSP_VALID and go to IDLE.
  - Y keeps its value until the next request is accepted.
- Latency:
  - Request accepted at edge 0; slices are written on edges 1..NUM_SLICES.
  - RSP_VALID is visible after edge NUM_SLICES (8 for defaults).
  - Response handshake at edge R makes REQ_READY = 1 after edge R. There is no overlap of the response with a new request.
  - Minimum spacing is NUM_SLICES+2 edges per operation.
- ZERO:
  - Registered, computed from the fully assembled Y.
  - Asserted in the same cycle as RSP_VALID, not from partial slices.
- Operand stability: A, B and OP may change freely after the accept edge. Only the registered copies are used.
- Counter width: $clog2(NUM_SLICES), minimum 1 bit. The counter does not wrap in BUSY because the exit happens at NUM_SLICES-1.
- RST mid-BUSY or mid-DONE: the operation is abandoned and the pending response is discarded. RSP_VALID = 0 and Y = 0 in the cycle after the reset edge. No partial response is ever signalled.
- Simultaneous RSP_READY and REQ_VALID in DONE: only the response completes. The request waits, with REQ_VALID held by the requester, until IDLE.

Decomposition:
- Shared package logic_seq_pkg:
  - OP codes: OP_AND, OP_OR, OP_NOR, OP_NOT.
  - State encoding: S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10.
  - Default widths.
- Sub-module logic_slice:
  - Combinational.
  - Inputs: SLICE_WIDTH-bit a and b, plus 2-bit op.
  - Output: SLICE_WIDTH-bit y.
  - Built from the team's existing gate-level primitives.
- Top level owns the FSM, counter, operand registers, result register and ZERO.

Test Plan:
1. Reset then AND: A=32'hF0F0_1234, B=32'hFF00_FF00, OP=00, accepted at edge 0, RSP_READY=1 -> RSP_VALID first high after edge 8, Y=32'hF000_1200, ZERO=0. REQ_READY high again one cycle after the response.
2. NOR to zero: A=32'hFFFF_FFFF, B=0, OP=10 -> Y=0, ZERO=1. Then NOT with A=0, OP=11, B=32'hDEAD_BEEF -> Y=32'hFFFF_FFFF, ZERO=0 (B ignored).
3. Backpressure: OR with A=32'h0000_00FF, B=32'h1234_0000, RSP_READY=0 for 20 cycles -> RSP_VALID, Y=32'h1234_00FF and ZERO stay stable. REQ_READY=0 and a REQ_VALID pulse is ignored. RSP_READY=1 completes the response.
4. Operand change after accept: A and B randomized every cycle during BUSY -> Y matches the values captured at the accept edge.
5. Reset mid-operation: assert RST at BUSY cnt=4 -> after that edge RSP_VALID=0 and Y=0; REQ_READY=0 while RST=1 and 1 on the first cycle after release. A new AND request then completes correctly with no stale slices.
6. Parameter sweep: SLICE_WIDTH = 1, 8 and 32 with random operands against a reference model -> RSP_VALID after NUM_SLICES edges (32, 4, 1), with Y and ZERO exact.

Source files
------------

// File: rtl/logic_seq_pkg.sv
// Shared definitions for the slice-serial logic unit: operation codes,
// FSM state encoding and default widths.
package logic_seq_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SLICE_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_NOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise slice built from gate primitives; NOT uses operand a
// only.
module logic_slice
  import logic_seq_pkg::*;
#(
  parameter int SLICE_WIDTH = SLICE_WIDTH_DEF
) (
  input  logic [SLICE_WIDTH-1:0] a,
  input  logic [SLICE_WIDTH-1:0] b,
  input  op_e                    op,
  output logic [SLICE_WIDTH-1:0] y
);

  logic [SLICE_WIDTH-1:0] and_s;
  logic [SLICE_WIDTH-1:0] or_s;
  logic [SLICE_WIDTH-1:0] nor_s;
  logic [SLICE_WIDTH-1:0] not_s;

  for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_bit
    and g_and (and_s[i], a[i], b[i]);
    or  g_or  (or_s[i],  a[i], b[i]);
    nor g_nor (nor_s[i], a[i], b[i]);
    not g_not (not_s[i], a[i]);
  end

  // Select the gate output for the registered operation.
  always_comb begin
    y = and_s;
    case (op)
      OP_AND:  y = and_s;
      OP_OR:   y = or_s;
      OP_NOR:  y = nor_s;
      OP_NOT:  y = not_s;
      default: y = and_s;
    endcase
  end

endmodule

// File: rtl/logic_seq_32_bit.sv
// Slice-serial logic unit: accepts a request, computes SLICE_WIDTH result bits
// per cycle, then holds the result and zero flag until the response is taken.
module logic_seq_32_bit
  import logic_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SLICE_WIDTH = SLICE_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  ZERO
);

  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int CW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int SHW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);

  state_e                 state_r;
  state_e                 state_s;
  logic [CW-1:0]          cnt_r;
  logic [DATA_WIDTH-1:0]  a_r;
  logic [DATA_WIDTH-1:0]  b_r;
  op_e                    op_r;
  logic [DATA_WIDTH-1:0]  y_r;
  logic                   zero_r;
  logic [SHW-1:0]         sh_s;
  logic [SLICE_WIDTH-1:0] slice_y_s;
  logic [DATA_WIDTH-1:0]  y_next_s;

  logic_slice #(.SLICE_WIDTH(SLICE_WIDTH)) u_slice (
    .a  (a_r[sh_s +: SLICE_WIDTH]),
    .b  (b_r[sh_s +: SLICE_WIDTH]),
    .op (op_r),
    .y  (slice_y_s)
  );

  // Slice base offset and the result with the current slice merged in.
  always_comb begin
    sh_s     = SHW'(cnt_r) * SHW'(SLICE_WIDTH);
    y_next_s = y_r;
    y_next_s[sh_s +: SLICE_WIDTH] = slice_y_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (REQ_VALID) state_s = S_BUSY;
        else           state_s = S_IDLE;
      end
      S_BUSY: begin
        if (cnt_r == LAST) state_s = S_DONE;
        else               state_s = S_BUSY;
      end
      S_DONE: begin
        if (RSP_READY) state_s = S_IDLE;
        else           state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, operand capture, slice accumulation and zero flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= OP_AND;
      y_r     <= '0;
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        S_IDLE: begin
          if (REQ_VALID) begin
            a_r    <= A;
            b_r    <= B;
            op_r   <= op_e'(OP);
            cnt_r  <= '0;
            y_r    <= '0;
            zero_r <= 1'b0;
          end
        end
        S_BUSY: begin
          y_r   <= y_next_s;
          cnt_r <= cnt_r + CW'(1);
          // Flag only from the fully assembled word, never from partial slices.
          if (cnt_r == LAST) zero_r <= (y_next_s == '0);
        end
        S_DONE: begin
          zero_r <= zero_r;
        end
        default: begin
          y_r <= '0;
        end
      endcase
    end
  end

  assign REQ_READY = (state_r == S_IDLE) && !RST;
  assign RSP_VALID = (state_r == S_DONE);
  assign Y         = y_r;
  assign ZERO      = zero_r;

endmodule
